uart_rx_ovs: RTL and testbench
==============================

Name: uart_rx_ovs

Overview:
Parametrised oversampling UART receiver. It is the receive-side successor to the fixed 8N1 uart_tx / baud_pulse_gen pair.
- Generates its own oversample tick and synchronises the rx pin.
- Majority-votes each bit at mid-bit.
- Supports 5–9 data bits, none/odd/even parity and 1 or 2 stop bits.
- Delivers words through a valid/ready output register with parity, framing and overrun reporting.
- Sits between the board rx pin and uart_demo loopback/command logic.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; even, >= 8.
- DATA_BITS, 8, data bits per frame; 5..9, LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; 1 or 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  receiver enable.
- rx  in  1  asynchronous serial input, idle high.
- out_ready  in  1  consumer accepts data_out.
- data_out  out  DATA_BITS  received word.
- out_valid  out  1  data_out holds an unconsumed word.
- parity_err  out  1  parity mismatch for data_out; always 0 when PARITY = 0.
- frame_err  out  1  a stop bit sampled low for data_out.
- overrun  out  1  one-cycle pulse: an unconsumed word was overwritten.
- busy  out  1  frame reception in progress (FSM not IDLE).

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. Every flop resets:
  - rx synchroniser flops to 1.
  - data_out to 0.
  - out_valid, parity_err, frame_err, overrun and busy to 0.
  - FSM to IDLE; counters to 0.
  - Reset mid-frame discards the partial frame.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD_RATE*OVERSAMPLE/2) / (BAUD_RATE*OVERSAMPLE), rounded; 14 at the defaults.
  - Counter 0..DIV-1; tick is high for one clk when the counter equals DIV-1.
  - The counter is held at 0 while en = 0.
- rx synchronisation: 2-flop synchroniser; the FSM sees rx_s, rx delayed by 2 clk.
- Majority vote: per bit, sample rx_s on the ticks with phase OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within the bit. The bit value is the majority of the 3 samples.
- Phase counter: 0..OVERSAMPLE-1, advancing on tick. It wraps to 0 and advances the bit index at OVERSAMPLE-1.
- FSM states and transitions:
  - IDLE: on a tick with rx_s = 0, go to START with phase = 1.
  - START: after the vote, a majority of 1 is a false start; return to IDLE at the phase OVERSAMPLE/2+1 tick with no output. Otherwise go to DATA at phase wrap.
  - DATA: shift DATA_BITS voted bits in, LSB first. Then go to PAR if PARITY != 0, else STOP.
  - PAR: vote one bit. perr = (XOR of data bits XOR parity bit) != (PARITY == 1). For example, even parity with an odd number of ones in the data requires a parity bit of 1.
  - STOP: vote STOP_BITS bits; ferr = 1 if any voted stop bit is 0. Commit at the OVERSAMPLE/2+1 tick of the last stop bit and go directly to IDLE. No full-bit wait, so a start bit in the second half of the stop bit is caught.
- en = 0: FSM forced to IDLE at the next clk; the output register and handshake are unaffected.
- busy = (state != IDLE), registered.
- Commit: in the clk after the commit tick:
  - data_out ← word, parity_err ← perr, frame_err ← ferr, out_valid ← 1.
  - Latency from the rx pin's mid-last-stop-bit sample to out_valid is 3 clk: 2 sync + 1 register.
- Handshake:
  - A transfer occurs on a clk where out_valid & out_ready.
  - A transfer without a commit clears out_valid; data_out and error flags hold their values.
  - out_valid never drops without a transfer.
- Simultaneous commit and transfer: the new word loads, out_valid stays 1, and there is no overrun.
- Commit with out_valid & !out_ready:
  - The new word and flags overwrite the register.
  - out_valid stays 1 and overrun pulses high for exactly 1 clk.
- Frames with a framing error are still delivered (data_out holds the shifted bits). A break, rx held low, yields data 0 with frame_err = 1. A new frame starts only after rx_s is seen high.

Test Plan:
- Defaults, en = 1, out_ready = 1, send 8N1 0xA5 at 224 clk/bit:
  - data_out = 0xA5, out_valid for 1 clk, parity_err = frame_err = 0.
  - busy high from start-edge+3 clk to commit.
- PARITY = 2, send 0x37 with parity bit 1:
  - parity_err = 0.
  - Resend 0x37 with parity bit 0 → data_out = 0x37, parity_err = 1.
  - With PARITY = 1 and parity bit 0 → parity_err = 0.
- Stop bit driven low: send 0x5A with a low stop bit → data_out = 0x5A, frame_err = 1. Then drive rx high, send 0x12 → frame_err = 0.
- Glitch: rx low for 42 clk (3 ticks) in idle → busy pulses, returns 0 without out_valid.
  - A single-tick low spike inside data bit 3 of 0xFF → data_out = 0xFF (majority vote).
- out_ready = 0, send 0x11 then 0x22 back-to-back:
  - After 0x11, out_valid = 1 with no overrun.
  - At the second commit, overrun pulses 1 clk, data_out = 0x22, out_valid stays 1.
  - Asserting out_ready clears out_valid the next clk.
- DATA_BITS = 9, STOP_BITS = 2: send 0x1C3 → data_out = 0x1C3.
  - Reset mid-data of a second frame → all outputs 0 immediately.
  - The next full frame 0x0F0 is received correctly.

Source files
------------

// File: rtl/uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// uart_rx_ovs
// Oversampling UART receiver with majority-voted bit sampling, 5..9 data
// bits, optional odd/even parity and 1 or 2 stop bits.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   en          receiver enable; low forces the FSM idle and parks the tick
//               divider, the output register is left alone
//   rx          asynchronous serial input, idle high
//   out_ready   consumer accepts data_out
//   data_out    received word (LSB was first on the line)
//   out_valid   data_out holds an unconsumed word
//   parity_err  parity mismatch for data_out (always 0 without parity)
//   frame_err   a stop bit was voted low for data_out
//   overrun     one-cycle pulse: an unconsumed word was overwritten
//   busy        frame reception in progress
//
// Output handshake: a transfer happens on every clk edge where
// out_valid && out_ready. out_valid only falls through a transfer; a new
// word committed in the same cycle as a transfer keeps out_valid high.
// ---------------------------------------------------------------------------
module uart_rx_ovs #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // Rounded clocks per oversample tick.
    localparam int DIV     = (CLK_FREQ + BAUD_RATE * OVERSAMPLE / 2) / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PH_W    = $clog2(OVERSAMPLE);
    localparam int HALF    = OVERSAMPLE / 2;
    localparam logic ODD_PAR = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Oversample tick generator
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_W'(DIV - 1)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // en gating only matters when DIV == 1 and the counter is always at its end.
    assign tick = en && (div_cnt == DIV_W'(DIV - 1));

    // ------------------------------------------------------------------
    // rx synchroniser (idle-high reset so no false start after reset)
    // ------------------------------------------------------------------
    logic rx_m;
    logic rx_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [3:0]            bit_q, bit_d;
    logic [1:0]            samp_q, samp_d;     // samples at phase HALF-1 and HALF
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    // Cleared when a frame ends on a low line (break / low stop bit) so
    // that a held-low line cannot immediately start another frame.
    logic                  armed_q, armed_d;
    logic                  busy_q;

    logic                  vote;
    logic                  ph_last;
    logic                  ph_vote;
    logic                  commit;
    logic                  commit_ferr;

    assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);
    assign ph_last = (phase_q == PH_W'(OVERSAMPLE - 1));
    assign ph_vote = (phase_q == PH_W'(HALF + 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        armed_d     = armed_q;
        commit      = 1'b0;
        commit_ferr = ferr_q | ~vote;

        if (rx_s) begin
            armed_d = 1'b1;
        end

        if (tick && (state_q != S_IDLE)) begin
            phase_d = ph_last ? '0 : phase_q + 1'b1;
            if (phase_q == PH_W'(HALF - 1)) begin
                samp_d[0] = rx_s;
            end
            if (phase_q == PH_W'(HALF)) begin
                samp_d[1] = rx_s;
            end
        end

        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    // The detecting tick counts as phase 0 of the start bit.
                    if (!rx_s && armed_q) begin
                        state_d = S_START;
                        phase_d = PH_W'(1);
                        bit_d   = '0;
                        perr_d  = 1'b0;
                        ferr_d  = 1'b0;
                    end
                end
                S_START: begin
                    if (ph_vote && vote) begin
                        state_d = S_IDLE;       // false start, no output
                        phase_d = '0;
                    end else if (ph_last) begin
                        state_d = S_DATA;
                        bit_d   = '0;
                    end
                end
                S_DATA: begin
                    if (ph_vote) begin
                        shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
                    end
                    if (ph_last) begin
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            state_d = (PARITY != 0) ? S_PAR : S_STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                S_PAR: begin
                    if (ph_vote) begin
                        perr_d = (^shreg_q) ^ vote ^ ODD_PAR;
                    end
                    if (ph_last) begin
                        state_d = S_STOP;
                        bit_d   = '0;
                    end
                end
                S_STOP: begin
                    if (ph_vote) begin
                        if (!vote) begin
                            ferr_d = 1'b1;
                        end
                        // Commit mid-way through the last stop bit so a start
                        // edge in its second half is still caught.
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            commit  = 1'b1;
                            state_d = S_IDLE;
                            phase_d = '0;
                            armed_d = rx_s;
                        end
                    end else if (ph_last) begin
                        bit_d = bit_q + 4'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    phase_d = '0;
                end
            endcase
        end

        if (!en) begin
            state_d = S_IDLE;
            phase_d = '0;
            bit_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Output register and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                data_out   <= shreg_q;
                parity_err <= perr_q;
                frame_err  <= commit_ferr;
                out_valid  <= 1'b1;
                overrun    <= out_valid & ~out_ready;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ovs.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ovs
// Three receivers with different framing share clk/rst_n, each with its own
// rx line, enable and ready:
//   u0: defaults, 8N1, 224 clk/bit
//   u1: 8 data, even parity, 1 stop, OVERSAMPLE 8, 24 clk/bit
//   u2: 9 data, odd parity, 2 stop, OVERSAMPLE 10, 50 clk/bit
// Expected words are derived from what is driven on the line and queued;
// a compare process pops one per handshake transfer.
// ---------------------------------------------------------------------------
module tb_uart_rx_ovs;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [2:0] en;
    logic [2:0] rdy;
    logic [2:0] rx;
    logic [2:0] vld, perr, ferr, ovr, busy;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic [8:0] dout [3];

    assign dout[0] = {1'b0, d0};
    assign dout[1] = {1'b0, d1};
    assign dout[2] = d2;

    uart_rx_ovs u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .rx(rx[0]), .out_ready(rdy[0]),
        .data_out(d0), .out_valid(vld[0]), .parity_err(perr[0]),
        .frame_err(ferr[0]), .overrun(ovr[0]), .busy(busy[0])
    );

    uart_rx_ovs #(
        .CLK_FREQ(25000000), .BAUD_RATE(1000000), .OVERSAMPLE(8),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .rx(rx[1]), .out_ready(rdy[1]),
        .data_out(d1), .out_valid(vld[1]), .parity_err(perr[1]),
        .frame_err(ferr[1]), .overrun(ovr[1]), .busy(busy[1])
    );

    uart_rx_ovs #(
        .CLK_FREQ(25000000), .BAUD_RATE(500000), .OVERSAMPLE(10),
        .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .rx(rx[2]), .out_ready(rdy[2]),
        .data_out(d2), .out_valid(vld[2]), .parity_err(perr[2]),
        .frame_err(ferr[2]), .overrun(ovr[2]), .busy(busy[2])
    );

    // ---------------- per-instance line parameters ----------------
    function automatic int bit_clks(input int i);
        case (i)
            0:       return 224;   // 14 clk/tick * 16
            1:       return 24;    // 3 clk/tick * 8
            default: return 50;    // 5 clk/tick * 10
        endcase
    endfunction

    function automatic int tick_clks(input int i);
        case (i)
            0:       return 14;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int nbits(input int i);
        return (i == 2) ? 9 : 8;
    endfunction

    function automatic int pmode(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int nstop(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    // ---------------- scoreboard ----------------
    // entry = {inst[1:0], parity_err, frame_err, data[8:0]}
    logic [12:0] exp_q[$];
    logic [12:0] last_got [3];
    int          xfer_cnt [3];
    int          ovr_cnt  [3];
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Compare process: half a cycle before the edge the DUT samples.
    initial begin
        logic [2:0] pv;
        logic [2:0] px;
        logic [12:0] got;
        logic [12:0] exp;
        pv = '0;
        px = '0;
        for (int i = 0; i < 3; i++) begin
            last_got[i] = '0;
            xfer_cnt[i] = 0;
            ovr_cnt[i]  = 0;
        end
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pv = '0;
                px = '0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (pv[i] && !px[i]) begin
                        check("valid_hold", {31'd0, vld[i]}, 32'd1);
                    end
                    if (ovr[i]) begin
                        ovr_cnt[i]++;
                        check("overrun_with_valid", {31'd0, vld[i]}, 32'd1);
                    end
                    if (vld[i] && rdy[i]) begin
                        got = {2'(i), perr[i], ferr[i], dout[i]};
                        last_got[i] = got;
                        xfer_cnt[i]++;
                        if (exp_q.size() == 0) begin
                            chk_cnt++;
                            $display("FAIL xfer_extra: got %0h expected no transfer", got);
                        end else begin
                            exp = exp_q.pop_front();
                            check("xfer_word", {19'd0, got}, {19'd0, exp});
                        end
                    end
                    pv[i] = vld[i];
                    px[i] = vld[i] & rdy[i];
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends one frame on line i. spike_bit >= 0 pulls that data bit low for
    // one tick-length window around its middle.
    task automatic send_frame(input int i, input logic [8:0] d, input logic bad_par,
                              input logic stop_low, input int spike_bit, input int gap);
        int bc;
        int nb;
        int pm;
        int ns;
        int ones;
        logic [8:0] w;
        logic pbit;
        bc = bit_clks(i);
        nb = nbits(i);
        pm = pmode(i);
        ns = nstop(i);
        w = d & 9'((1 << nb) - 1);
        ones = $countones(w);
        // odd: data+parity has an odd number of ones; even: an even number
        pbit = (pm == 1) ? ~ones[0] : ones[0];
        if (bad_par) pbit = ~pbit;
        if (en[i]) exp_q.push_back({2'(i), (pm != 0) && bad_par, stop_low, w});

        @(negedge clk);
        rx[i] = 1'b0;
        wait_clks(bc / 2);
        check("busy_mid_start", {31'd0, busy[i]}, {31'd0, en[i]});
        wait_clks(bc - bc / 2 - 1);
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            rx[i] = w[b];
            if (b == spike_bit) begin
                wait_clks(bc / 2 - tick_clks(i) / 2 - 1);
                rx[i] = 1'b0;
                wait_clks(tick_clks(i));
                rx[i] = w[b];
                wait_clks(bc - bc / 2 - (tick_clks(i) - tick_clks(i) / 2));
            end else begin
                wait_clks(bc - 1);
            end
        end
        if (pm != 0) begin
            @(negedge clk);
            rx[i] = pbit;
            wait_clks(bc - 1);
        end
        for (int s = 0; s < ns; s++) begin
            @(negedge clk);
            rx[i] = !(stop_low && (s == 0));
            wait_clks(bc - 1);
        end
        @(negedge clk);
        rx[i] = 1'b1;
        wait_clks(gap);
        check("busy_after_frame", {31'd0, busy[i]}, 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        for (int i = 0; i < 3; i++) begin
            check(name, {18'd0, dout[i], vld[i], perr[i], ferr[i], ovr[i], busy[i]}, 32'd0);
        end
    endtask

    task automatic send_random(input int i, input int n);
        int bc;
        for (int k = 0; k < n; k++) begin
            bc = bit_clks(i);
            send_frame(i, 9'($urandom_range(0, 511)),
                       (pmode(i) != 0) && ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 4) == 0, -1,
                       bc * $urandom_range(1, 2) + $urandom_range(0, tick_clks(i)));
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int xc;
        logic seen;
        rst_n = 1'b0;
        en    = 3'b111;
        rdy   = 3'b111;
        rx    = 3'b111;
        wait_clks(3);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        wait_clks(20);

        // ---- u0: 8N1 directed ----
        send_frame(0, 9'h0A5, 1'b0, 1'b0, -1, 224);
        check("u0_a5", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b0, 9'h0A5});

        send_frame(0, 9'h05A, 1'b0, 1'b1, -1, 224);
        check("u0_5a_low_stop", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b1, 9'h05A});

        send_frame(0, 9'h012, 1'b0, 1'b0, -1, 224);
        check("u0_12", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b0, 9'h012});

        // idle glitch of three ticks: false start
        xc = xfer_cnt[0];
        seen = 1'b0;
        rx[0] = 1'b0;
        for (int k = 0; k < 42; k++) begin
            @(negedge clk);
            if (busy[0]) seen = 1'b1;
        end
        rx[0] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy[0]) seen = 1'b1;
        end
        check("glitch_busy_seen", {31'd0, seen}, 32'd1);
        check("glitch_busy_end", {31'd0, busy[0]}, 32'd0);
        check("glitch_no_word", xfer_cnt[0], xc);

        // one-tick spike inside data bit 3 is outvoted
        send_frame(0, 9'h0FF, 1'b0, 1'b0, 3, 224);
        check("u0_ff_spike", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b0, 9'h0FF});

        // break: line held low, one word of zeros with frame error, no restart
        exp_q.push_back({2'd0, 1'b0, 1'b1, 9'h000});
        @(negedge clk);
        rx[0] = 1'b0;
        wait_clks(224 * 11);
        check("break_no_restart", {31'd0, busy[0]}, 32'd0);
        wait_clks(224);
        rx[0] = 1'b1;
        wait_clks(448);
        check("u0_break", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b1, 9'h000});

        // disabled receiver ignores a frame
        xc = xfer_cnt[0];
        en[0] = 1'b0;
        send_frame(0, 9'h03C, 1'b0, 1'b0, -1, 224);
        check("disabled_no_word", xfer_cnt[0], xc);
        en[0] = 1'b1;
        wait_clks(224);

        // overrun: two words with no consumer
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 1'b0, 1'b0, -1, 0);
        check("ovr_first_held", {22'd0, vld[0], dout[0]}, {22'd0, 1'b1, 9'h011});
        check("ovr_none_yet", ovr_cnt[0], 0);
        send_frame(0, 9'h022, 1'b0, 1'b0, -1, 0);
        exp_q.delete(0);   // 0x11 was overwritten and is never delivered
        check("ovr_one_pulse", ovr_cnt[0], 1);
        check("ovr_second_held", {22'd0, vld[0], dout[0]}, {22'd0, 1'b1, 9'h022});
        rdy[0] = 1'b1;
        @(negedge clk);
        check("ovr_drained", {31'd0, vld[0]}, 32'd0);
        check("u0_22", {19'd0, last_got[0]}, {19'd0, 2'd0, 1'b0, 1'b0, 9'h022});
        wait_clks(224);

        send_random(0, 3);

        // ---- u1: even parity ----
        send_frame(1, 9'h037, 1'b0, 1'b0, -1, 48);
        check("u1_37_good", {19'd0, last_got[1]}, {19'd0, 2'd1, 1'b0, 1'b0, 9'h037});
        send_frame(1, 9'h037, 1'b1, 1'b0, -1, 48);
        check("u1_37_bad", {19'd0, last_got[1]}, {19'd0, 2'd1, 1'b1, 1'b0, 9'h037});
        send_random(1, 10);

        // ---- u2: 9 data, odd parity, 2 stop ----
        send_frame(2, 9'h037, 1'b0, 1'b0, -1, 100);
        check("u2_37_odd", {19'd0, last_got[2]}, {19'd0, 2'd2, 1'b0, 1'b0, 9'h037});
        rdy[2] = 1'b0;
        send_frame(2, 9'h1C3, 1'b0, 1'b0, -1, 100);
        check("u2_1c3_held", {20'd0, perr[2], ferr[2], vld[2], dout[2]},
              {20'd0, 1'b0, 1'b0, 1'b1, 9'h1C3});
        // partial frame then reset: everything clears, partial frame discarded
        @(negedge clk);
        rx[2] = 1'b0;
        wait_clks(50);
        rx[2] = 1'b1;
        wait_clks(50);
        rx[2] = 1'b0;
        wait_clks(50);
        rx[2] = 1'b1;
        wait_clks(25);
        check("u2_busy_mid_data", {31'd0, busy[2]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        exp_q.delete();    // reset discards the held word
        @(negedge clk);
        rx[2] = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        rdy[2] = 1'b1;
        wait_clks(100);
        send_frame(2, 9'h0F0, 1'b0, 1'b0, -1, 100);
        check("u2_0f0", {19'd0, last_got[2]}, {19'd0, 2'd2, 1'b0, 1'b0, 9'h0F0});
        send_random(2, 10);

        // ---- end of run ----
        wait_clks(20);
        check("queue_drained", exp_q.size(), 0);
        check("u1_no_overrun", ovr_cnt[1], 0);
        check("u2_no_overrun", ovr_cnt[2], 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
